// File: rtl/mult_arbiter_pkg.sv
// Shared types for the two-requester multiplier arbiter.
package mult_arbiter_pkg;

    // Arbiter FSM states; the encodings match the original 2-bit values.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        ACK  = 2'd2
    } state_t;

endpackage

// File: rtl/mult_arbiter_mult.sv
// Combinational unsigned multiplier, N x N -> 2N with no truncation.
module mult #(
    parameter int N = 4
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] p
);

    // Operands are widened first so the full 2N-bit product is formed.
    assign p = {{N{1'b0}}, a} * {{N{1'b0}}, b};

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one multiplier between two 4-phase
// req/ack requesters. Operands and product are registered.
module mult_arbiter
    import mult_arbiter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic           Clock,
    input  logic           Resetn,
    input  logic           req0,
    input  logic [N-1:0]   a0,
    input  logic [N-1:0]   b0,
    input  logic           req1,
    input  logic [N-1:0]   a1,
    input  logic [N-1:0]   b1,
    output logic           ack0,
    output logic           ack1,
    output logic [2*N-1:0] p,
    output logic           busy
);

    state_t         state;
    logic [N-1:0]   op_a;
    logic [N-1:0]   op_b;
    logic           grant;
    logic           last;
    logic           pick;
    logic [2*N-1:0] prod;

    mult #(.N(N)) u_mult (
        .a (op_a),
        .b (op_b),
        .p (prod)
    );

    // Winner selection: a lone request wins, otherwise alternate away from last served.
    always_comb begin
        pick = 1'b0;
        if (req0 && req1) begin
            pick = ~last;
        end else if (req1) begin
            pick = 1'b1;
        end
    end

    // Arbiter FSM; busy is registered alongside the state so it equals (state != IDLE).
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= IDLE;
            ack0  <= 1'b0;
            ack1  <= 1'b0;
            p     <= '0;
            busy  <= 1'b0;
            op_a  <= '0;
            op_b  <= '0;
            grant <= 1'b0;
            last  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        grant <= pick;
                        op_a  <= pick ? a1 : a0;
                        op_b  <= pick ? b1 : b0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    p     <= prod;
                    ack0  <= ~grant;
                    ack1  <= grant;
                    state <= ACK;
                end
                ACK: begin
                    if (grant ? !req1 : !req0) begin
                        ack0  <= 1'b0;
                        ack1  <= 1'b0;
                        last  <= grant;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter: stimulus pushes expected {id, product},
// a monitor pops and compares on every rising ack.
module tb_mult_arbiter;

    localparam int N = 4;

    logic           Clock;
    logic           Resetn;
    logic           req0;
    logic [N-1:0]   a0;
    logic [N-1:0]   b0;
    logic           req1;
    logic [N-1:0]   a1;
    logic [N-1:0]   b1;
    logic           ack0;
    logic           ack1;
    logic [2*N-1:0] p;
    logic           busy;

    typedef struct packed {
        logic           id;
        logic [2*N-1:0] prod;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errs   = 0;

    mult_arbiter #(.N(N)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .req0   (req0),
        .a0     (a0),
        .b0     (b0),
        .req1   (req1),
        .a1     (a1),
        .b1     (b1),
        .ack0   (ack0),
        .ack1   (ack1),
        .p      (p),
        .busy   (busy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Monitor: pop the scoreboard on each rising ack, and check ack exclusivity.
    initial begin
        logic pa0, pa1;
        exp_t e;
        pa0 = 1'b0;
        pa1 = 1'b0;
        forever begin
            @(negedge Clock);
            if (ack0 || ack1) begin
                checks++;
                if (ack0 && ack1) begin
                    errs++;
                    $display("FAIL ack_excl: ack0=%0d ack1=%0d, required not both high", ack0, ack1);
                end
            end
            if ((ack0 && !pa0) || (ack1 && !pa1)) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errs++;
                    $display("FAIL unexpected_ack: ack0=%0d ack1=%0d p=%0d, required no ack", ack0, ack1, p);
                end else begin
                    e = exp_q.pop_front();
                    if (ack1 !== e.id || ack0 !== !e.id || p !== e.prod) begin
                        errs++;
                        $display("FAIL result: ack0=%0d ack1=%0d p=%0d, required id=%0d p=%0d",
                                 ack0, ack1, p, e.id, e.prod);
                    end
                end
            end
            pa0 = ack0;
            pa1 = ack1;
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic expect_res(input logic id, input int prod);
        exp_t e;
        e.id   = id;
        e.prod = prod[2*N-1:0];
        exp_q.push_back(e);
    endtask

    // Wait (bounded) for the ack of requester id, check latency, release req,
    // then check the handshake closes one cycle later.
    task automatic serve(input logic id, input int exp_lat);
        int n;
        bit got;
        n   = 0;
        got = 0;
        while (!got && n < 20) begin
            @(negedge Clock);
            n++;
            if (id ? ack1 : ack0) got = 1;
        end
        checks++;
        if (!got || n != exp_lat) begin
            errs++;
            $display("FAIL latency_req%0d: waited %0d cycles (ack seen=%0d), required %0d",
                     id, n, got, exp_lat);
        end
        if (id) req1 = 1'b0; else req0 = 1'b0;
        @(negedge Clock);
        chk("ack_release", {14'd0, ack1, ack0}, 16'd0);
        chk("busy_release", {15'd0, busy}, 16'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        Resetn = 1'b0;
        req0 = 1'b1; a0 = 4'd3; b0 = 4'd5;
        req1 = 1'b0; a1 = '0;   b1 = '0;

        // Reset held with req0 high: everything stays cleared.
        repeat (3) @(negedge Clock);
        chk("rst_ack", {14'd0, ack1, ack0}, 16'd0);
        chk("rst_p", {8'd0, p}, 16'd0);
        chk("rst_busy", {15'd0, busy}, 16'd0);

        // Single request 3x5 = 15, served on release.
        expect_res(1'b0, 15);
        Resetn = 1'b1;
        serve(1'b0, 2);
        chk("p_hold_15", {8'd0, p}, 16'd15);

        // Simultaneous requests from reset with alternation.
        Resetn = 1'b0;
        a0 = 4'd15; b0 = 4'd15; a1 = 4'd2; b1 = 4'd7;
        req0 = 1'b1; req1 = 1'b1;
        repeat (2) @(negedge Clock);
        chk("rst2_p", {8'd0, p}, 16'd0);
        expect_res(1'b0, 225);
        expect_res(1'b1, 14);
        expect_res(1'b0, 225);
        expect_res(1'b1, 14);
        Resetn = 1'b1;
        serve(1'b0, 2);
        serve(1'b1, 2);
        req0 = 1'b1; req1 = 1'b1;
        serve(1'b0, 2);
        serve(1'b1, 2);
        chk("p_hold_14", {8'd0, p}, 16'd14);

        // Held-off request: req1 raised while requester 0 is in CALC.
        expect_res(1'b0, 12);
        expect_res(1'b1, 0);
        a0 = 4'd6; b0 = 4'd2; req0 = 1'b1;
        @(negedge Clock);
        chk("busy_calc", {15'd0, busy}, 16'd1);
        a1 = 4'd0; b1 = 4'd9; req1 = 1'b1;
        serve(1'b0, 1);
        serve(1'b1, 2);

        // Operand change after grant is ignored: 4x4 = 16.
        expect_res(1'b0, 16);
        a0 = 4'd4; b0 = 4'd4; req0 = 1'b1;
        @(negedge Clock);
        a0 = 4'd9;
        serve(1'b0, 1);

        // Granted req dropped during CALC: ack pulses exactly one cycle.
        expect_res(1'b0, 21);
        a0 = 4'd7; b0 = 4'd3; req0 = 1'b1;
        @(negedge Clock);
        req0 = 1'b0;
        @(negedge Clock);
        chk("drop_ack_on", {15'd0, ack0}, 16'd1);
        @(negedge Clock);
        chk("drop_ack_off", {15'd0, ack0}, 16'd0);
        chk("drop_busy", {15'd0, busy}, 16'd0);

        // Mid-operation reset during CALC: immediate clear, no ack afterwards.
        a0 = 4'd5; b0 = 4'd5; req0 = 1'b1;
        @(negedge Clock);
        Resetn = 1'b0;
        #1;
        chk("midrst_ack", {14'd0, ack1, ack0}, 16'd0);
        chk("midrst_p", {8'd0, p}, 16'd0);
        chk("midrst_busy", {15'd0, busy}, 16'd0);
        req0 = 1'b0;
        repeat (2) @(negedge Clock);
        Resetn = 1'b1;
        repeat (4) @(negedge Clock);
        chk("post_rst_idle", {14'd0, ack1, ack0}, 16'd0);

        chk("scoreboard_empty", exp_q.size(), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
        $finish;
    end

endmodule
